// File: rtl/fifo_wr_gen.sv
// FIFO write-side traffic generator: waits for an empty FIFO, then bursts INC/LFSR/CONST/WALK1
// pattern words until the FIFO reports full or the programmed word count is reached.
module fifo_wr_gen #(
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       CNT_W     = 16,
   parameter logic [DATA_W-1:0] LFSR_POLY = 8'hB8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] seed,
   input  logic [CNT_W-1:0]  burst_len,
   input  logic              wrempty,
   input  logic              wrfull,
   output logic [DATA_W-1:0] data,
   output logic              wrreq,
   output logic              busy,
   output logic              burst_done,
   output logic [CNT_W-1:0]  word_cnt
);

   typedef enum logic [1:0] {StIdle, StWaitEmpty, StWrite, StDone} state_e;

   localparam logic [1:0]        MODE_INC   = 2'd0;
   localparam logic [1:0]        MODE_LFSR  = 2'd1;
   localparam logic [1:0]        MODE_CONST = 2'd2;
   localparam logic [1:0]        MODE_WALK1 = 2'd3;
   localparam logic [DATA_W-1:0] DATA_ONE   = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

   state_e            state_q;
   logic [1:0]        mode_q;
   logic [CNT_W-1:0]  len_q;
   logic [DATA_W-1:0] data_q;
   logic              wrreq_q;
   logic              busy_q;
   logic              done_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              accept;
   logic              len_hit;
   logic [CNT_W-1:0]  cnt_inc;
   logic [DATA_W-1:0] data_next;
   logic [DATA_W-1:0] data_start;

   always_comb begin
      accept  = wrreq_q & ~wrfull;
      cnt_inc = cnt_q + CNT_ONE;
      // burst_len == 0 means no word limit: only wrfull ends the burst
      len_hit = (len_q != '0) && (cnt_inc == len_q);

      data_next = data_q;
      case (mode_q)
         MODE_INC:   data_next = data_q + DATA_ONE;
         MODE_LFSR:  data_next = data_q[0] ? ((data_q >> 1) ^ LFSR_POLY) : (data_q >> 1);
         MODE_CONST: data_next = data_q;
         MODE_WALK1: data_next = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
         default:    data_next = data_q;
      endcase

      // An all-zero seed would lock up both the LFSR and the walking one
      data_start = seed;
      if (((mode == MODE_LFSR) || (mode == MODE_WALK1)) && (seed == '0)) begin
         data_start = DATA_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         mode_q  <= MODE_INC;
         len_q   <= '0;
         data_q  <= '0;
         wrreq_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (en) begin
                  state_q <= StWaitEmpty;
                  busy_q  <= 1'b1;
               end
            end
            StWaitEmpty: begin
               if (!en) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (wrempty) begin
                  state_q <= StWrite;
                  wrreq_q <= 1'b1;
                  data_q  <= data_start;
                  mode_q  <= mode;
                  len_q   <= burst_len;
                  cnt_q   <= '0;
               end
            end
            StWrite: begin
               if (!en) begin
                  // Abort: no completion pulse and the word count is left as is
                  state_q <= StIdle;
                  wrreq_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else begin
                  if (accept) begin
                     data_q <= data_next;
                     if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_inc;
                     end
                  end
                  if (wrfull || (accept && len_hit)) begin
                     state_q <= StDone;
                     wrreq_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            StDone: begin
               if (en) begin
                  state_q <= StWaitEmpty;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
               wrreq_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data       = data_q;
   assign wrreq      = wrreq_q;
   assign busy       = busy_q;
   assign burst_done = done_q;
   assign word_cnt   = cnt_q;

endmodule
